icache_direct: RTL and testbench
================================

# icache_direct

Direct-mapped, one-word-per-line instruction cache between the instruction-fetch stage and the memory controller's fetch port. Hits return an instruction one cycle after the request. Misses raise `fetch_enable` to the memory controller, wait for its single-cycle `i_cache_valid` pulse, fill the line, and forward the word. A `clear` input from the pipeline discards an in-flight result after branch mispredicts without aborting the memory transaction.

## Interface
- `INDEX_BITS`, default 6: line count is 2^INDEX_BITS; index = `addr[INDEX_BITS+1:2]`; tag = `addr[31:INDEX_BITS+2]`.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `rdy` input 1: global enable; low freezes all state and outputs.
- `clear` input 1: pipeline flush; discard the pending request and result.
- `fetch_req` input 1: IF request, level.
- `fetch_pc` input 32: request address; `[1:0]` ignored.
- `inst_valid` output 1: one-cycle pulse; `inst` is valid.
- `inst` output 32: instruction word.
- `fetch_enable` output 1: to memory controller; miss fill request.
- `inst_addr` output 32: fill address, word-aligned (`{pc[31:2],2'b00}`).
- `mem_valid` input 1: memory controller `i_cache_valid`; one-cycle pulse.
- `mem_data` input 32: memory controller `i_cache_data`; valid with `mem_valid`.
- `invalidate` input 1: present only with `ICACHE_INVALIDATE_EN`.

## Operation
- Storage per line: valid bit, tag, and 32-bit data. Only valid bits are reset.
- Reset values: state IDLE, all valid bits 0, `inst_valid`=0, `inst`=0, `fetch_enable`=0, `inst_addr`=0, discard flag 0.
- States:
  - IDLE: default; accepts `fetch_req`.
  - MISS: fill outstanding.
- IDLE with `fetch_req` and no `clear`:
  - Hit (valid and tag equal): `inst`<=data, `inst_valid`<=1; stay IDLE.
  - Miss: `fetch_enable`<=1, `inst_addr`<=aligned pc; latch index/tag; go to MISS.
- MISS: hold `fetch_enable` and `inst_addr` stable until `mem_valid`. On `mem_valid`:
  - Write data, tag and valid bit to the latched line.
  - `fetch_enable`<=0; go to IDLE.
  - If the discard flag is 0: `inst`<=`mem_data`, `inst_valid`<=1.
  - If the discard flag is 1: `inst_valid` stays 0; clear the flag.
- `inst_valid` is high for exactly one cycle; it is cleared on every other active cycle.
- IF holds `fetch_req`/`fetch_pc` until it sees `inst_valid`. A request that is high in the `inst_valid` cycle is a new request.
- `clear` in IDLE: the request that cycle is ignored; `inst_valid`<=0.
- `clear` in MISS: set the discard flag. The fill still completes and the line is written, because the memory controller cannot abort.
- `clear` in the same cycle as `mem_valid`: the line is written and `inst_valid` is suppressed.
- `fetch_req` in MISS is ignored.
- `mem_valid` outside MISS is ignored.

## Timing
- Hit: request sampled at edge N; `inst_valid` high during cycle N+1.
- Miss:
  - `fetch_enable` high from N+1.
  - `inst_valid` high in the cycle after the edge that samples `mem_valid`.
  - `fetch_enable` falls at that same edge, before the memory controller's post-transfer idle cycle ends, so no duplicate fetch is issued.
- `rdy`=0: no state, storage or output changes. A `mem_valid` pulse arriving while `rdy`=0 is not expected, because the memory controller freezes under the same `rdy`.
- `rst` mid-miss: immediate return to reset values. Partially filled lines are never marked valid.

## Configuration
- `ICACHE_INVALIDATE_EN` defined:
  - Adds the `invalidate` input. When it is sampled high, all valid bits clear in one cycle (fence.i).
  - If it coincides with a fill write, the filled line's valid bit stays 0; `inst_valid` is still delivered per the `clear` rules.
  - A hit lookup in the same cycle as `invalidate` is treated as a miss.
- `ICACHE_INVALIDATE_EN` undefined: no `invalidate` port; valid bits clear only on `rst`.

## Test plan
- Reset, then request 0x00000100; memory returns 0x00A00093 → `fetch_enable`=1 with `inst_addr`=0x00000100, then a one-cycle `inst_valid` with `inst`=0x00A00093.
- Re-request 0x00000102 → hit; `inst_valid` next cycle with 0x00A00093; `fetch_enable` stays 0.
- INDEX_BITS=6: fill 0x100, then fill 0x200 (same index 0, different tag) → miss and refill; a later request to 0x100 misses again.
- Assert `clear` two cycles into the miss on 0x300 → no `inst_valid`. A later request to 0x300 hits in one cycle with the filled data.
- Hold `rdy`=0 for 5 cycles mid-miss → `fetch_enable`, `inst_addr` and state unchanged; completion resumes after `rdy` returns to 1.
- With `ICACHE_INVALIDATE_EN`: fill 0x100, pulse `invalidate`, re-request 0x100 → miss with `fetch_enable`=1.

Source files
------------

// File: rtl/icache_direct_if.sv
// icache_direct_if: fetch-stage and memory-controller signals of the direct-mapped instruction cache.
interface icache_direct_if;
   logic        rdy;
   logic        clear;
   logic        fetch_req;
   logic [31:0] fetch_pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic        fetch_enable;
   logic [31:0] inst_addr;
   logic        mem_valid;
   logic [31:0] mem_data;
   modport master (
      output rdy, clear, fetch_req, fetch_pc, mem_valid, mem_data,
      input  inst_valid, inst, fetch_enable, inst_addr
   );
   modport slave (
      input  rdy, clear, fetch_req, fetch_pc, mem_valid, mem_data,
      output inst_valid, inst, fetch_enable, inst_addr
   );
endinterface

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped one-word-per-line instruction cache with single-fill miss handling.
// Define ICACHE_INVALIDATE_EN to add the invalidate (fence.i) input that clears every valid bit.
module icache_direct #(
   parameter int INDEX_BITS = 6
) (
   input logic clk,
   input logic rst,
`ifdef ICACHE_INVALIDATE_EN
   input logic invalidate,
`endif
   icache_direct_if.slave bus
);
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 30 - INDEX_BITS;
   typedef enum logic {IDLE, MISS} state_t;
   state_t                state, state_d;
   logic [LINES-1:0]      valid;
   logic [TAG_BITS-1:0]   tags [LINES];
   logic [31:0]           data [LINES];
   logic                  inst_valid_q, inst_valid_d;
   logic [31:0]           inst_q, inst_d;
   logic                  fetch_enable_q, fetch_enable_d;
   logic [31:2]           addr_q, addr_d;
   logic                  discard, discard_d;
   logic                  inv, accept, hit, fill, deliver;
   logic [INDEX_BITS-1:0] req_idx, fill_idx;
   logic [TAG_BITS-1:0]   req_tag, fill_tag;
`ifdef ICACHE_INVALIDATE_EN
   assign inv = invalidate;
`else
   assign inv = 1'b0;
`endif
   assign req_idx  = bus.fetch_pc[INDEX_BITS+1:2];
   assign req_tag  = bus.fetch_pc[31:INDEX_BITS+2];
   // the latched fill address doubles as the line index/tag of the outstanding miss
   assign fill_idx = addr_q[INDEX_BITS+1:2];
   assign fill_tag = addr_q[31:INDEX_BITS+2];
   assign hit      = valid[req_idx] && (tags[req_idx] == req_tag) && !inv;
   assign accept   = (state == IDLE) && bus.fetch_req && !bus.clear;
   assign fill     = (state == MISS) && bus.mem_valid;
   assign deliver  = fill && !discard && !bus.clear;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else if (bus.rdy) state <= state_d;
   end
   always_comb begin
      state_d = state;
      if (state == IDLE) state_d = (accept && !hit) ? MISS : IDLE;
      else state_d = bus.mem_valid ? IDLE : MISS;
   end
   always_comb begin
      inst_valid_d   = (accept && hit) || deliver;
      inst_d         = (accept && hit) ? data[req_idx] : deliver ? bus.mem_data : inst_q;
      fetch_enable_d = (accept && !hit) ? 1'b1 : fill ? 1'b0 : fetch_enable_q;
      addr_d         = (accept && !hit) ? bus.fetch_pc[31:2] : addr_q;
      discard_d      = (state == MISS) && !bus.mem_valid && (discard || bus.clear);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid          <= '0;
         inst_valid_q   <= 1'b0;
         inst_q         <= '0;
         fetch_enable_q <= 1'b0;
         addr_q         <= '0;
         discard        <= 1'b0;
      end else if (bus.rdy) begin
         if (inv) valid <= '0;
         else if (fill) valid[fill_idx] <= 1'b1;
         inst_valid_q   <= inst_valid_d;
         inst_q         <= inst_d;
         fetch_enable_q <= fetch_enable_d;
         addr_q         <= addr_d;
         discard        <= discard_d;
      end
   end
   // tag and data arrays carry no reset; only valid bits decide a hit
   always_ff @(posedge clk) begin
      if (bus.rdy && fill) begin
         tags[fill_idx] <= fill_tag;
         data[fill_idx] <= bus.mem_data;
      end
   end
   assign bus.inst_valid   = inst_valid_q;
   assign bus.inst         = inst_q;
   assign bus.fetch_enable = fetch_enable_q;
   assign bus.inst_addr    = {addr_q, 2'b00};
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed checks of hit/miss timing, clear/discard, rdy stall and reset for icache_direct.
module tb_icache_direct;
   logic clk = 1'b0;
   logic rst = 1'b1;
`ifdef ICACHE_INVALIDATE_EN
   logic invalidate = 1'b0;
`endif
   int total = 0;
   int bad = 0;
   icache_direct_if bus ();
   icache_direct #(.INDEX_BITS(6)) dut (
      .clk(clk),
      .rst(rst),
`ifdef ICACHE_INVALIDATE_EN
      .invalidate(invalidate),
`endif
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic request(input logic [31:0] pc);
      bus.fetch_req = 1'b1;
      bus.fetch_pc  = pc;
      tick();
   endtask
   task automatic mem_return(input logic [31:0] d);
      bus.mem_valid = 1'b1;
      bus.mem_data  = d;
      tick();
      bus.mem_valid = 1'b0;
      bus.fetch_req = 1'b0;
   endtask
   initial begin
      bus.rdy = 1'b1; bus.clear = 1'b0; bus.fetch_req = 1'b0; bus.fetch_pc = '0;
      bus.mem_valid = 1'b0; bus.mem_data = '0;
      tick(); tick();
      chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
      chk("rst_inst", bus.inst, 32'd0);
      chk("rst_fetch_enable", {31'd0, bus.fetch_enable}, 32'd0);
      chk("rst_inst_addr", bus.inst_addr, 32'd0);
      rst = 1'b0;
      // cold miss on 0x100
      request(32'h0000_0100);
      chk("miss100_fe", {31'd0, bus.fetch_enable}, 32'd1);
      chk("miss100_addr", bus.inst_addr, 32'h0000_0100);
      chk("miss100_iv", {31'd0, bus.inst_valid}, 32'd0);
      tick();
      chk("miss100_fe_hold", {31'd0, bus.fetch_enable}, 32'd1);
      mem_return(32'h00A0_0093);
      chk("fill100_iv", {31'd0, bus.inst_valid}, 32'd1);
      chk("fill100_inst", bus.inst, 32'h00A0_0093);
      chk("fill100_fe", {31'd0, bus.fetch_enable}, 32'd0);
      tick();
      chk("fill100_pulse", {31'd0, bus.inst_valid}, 32'd0);
      // mem_valid in IDLE has no effect
      bus.mem_valid = 1'b1; bus.mem_data = 32'hDEAD_BEEF;
      tick();
      bus.mem_valid = 1'b0;
      chk("stray_mem_iv", {31'd0, bus.inst_valid}, 32'd0);
      chk("stray_mem_fe", {31'd0, bus.fetch_enable}, 32'd0);
      // hit with unaligned pc
      request(32'h0000_0102);
      chk("hit102_iv", {31'd0, bus.inst_valid}, 32'd1);
      chk("hit102_inst", bus.inst, 32'h00A0_0093);
      chk("hit102_fe", {31'd0, bus.fetch_enable}, 32'd0);
      bus.fetch_req = 1'b0;
      tick();
      chk("hit102_pulse", {31'd0, bus.inst_valid}, 32'd0);
      // conflict miss: 0x200 evicts 0x100 at index 0
      request(32'h0000_0200);
      chk("miss200_fe", {31'd0, bus.fetch_enable}, 32'd1);
      chk("miss200_addr", bus.inst_addr, 32'h0000_0200);
      mem_return(32'h1111_1111);
      chk("fill200_inst", bus.inst, 32'h1111_1111);
      tick();
      request(32'h0000_0100);
      chk("remiss100_fe", {31'd0, bus.fetch_enable}, 32'd1);
      chk("remiss100_iv", {31'd0, bus.inst_valid}, 32'd0);
      mem_return(32'h00A0_0093);
      chk("refill100_inst", bus.inst, 32'h00A0_0093);
      tick();
      // clear two cycles into a miss discards the result but fills the line
      request(32'h0000_0300);
      tick();
      bus.clear = 1'b1; bus.fetch_req = 1'b0;
      tick();
      bus.clear = 1'b0;
      chk("clr300_fe", {31'd0, bus.fetch_enable}, 32'd1);
      mem_return(32'h2222_2222);
      chk("clr300_iv", {31'd0, bus.inst_valid}, 32'd0);
      chk("clr300_fe_drop", {31'd0, bus.fetch_enable}, 32'd0);
      tick();
      request(32'h0000_0300);
      chk("hit300_iv", {31'd0, bus.inst_valid}, 32'd1);
      chk("hit300_inst", bus.inst, 32'h2222_2222);
      chk("hit300_fe", {31'd0, bus.fetch_enable}, 32'd0);
      bus.fetch_req = 1'b0;
      tick();
      // clear coinciding with mem_valid
      request(32'h0000_0400);
      bus.clear = 1'b1;
      mem_return(32'h4444_4444);
      bus.clear = 1'b0;
      chk("clr400_iv", {31'd0, bus.inst_valid}, 32'd0);
      tick();
      request(32'h0000_0400);
      chk("hit400_inst", bus.inst, 32'h4444_4444);
      chk("hit400_iv", {31'd0, bus.inst_valid}, 32'd1);
      bus.fetch_req = 1'b0;
      tick();
      // rdy low freezes a miss in progress
      request(32'h0000_0504);
      bus.rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_fe", {31'd0, bus.fetch_enable}, 32'd1);
         chk("stall_addr", bus.inst_addr, 32'h0000_0504);
      end
      bus.rdy = 1'b1;
      mem_return(32'h3333_3333);
      chk("stall_iv", {31'd0, bus.inst_valid}, 32'd1);
      chk("stall_inst", bus.inst, 32'h3333_3333);
      tick();
      // asynchronous reset mid-miss
      request(32'h0000_0600);
      chk("miss600_fe", {31'd0, bus.fetch_enable}, 32'd1);
      rst = 1'b1;
      #1;
      chk("arst_fe", {31'd0, bus.fetch_enable}, 32'd0);
      chk("arst_addr", bus.inst_addr, 32'd0);
      bus.fetch_req = 1'b0;
      tick();
      rst = 1'b0;
      request(32'h0000_0400);
      chk("postrst_miss_fe", {31'd0, bus.fetch_enable}, 32'd1);
      chk("postrst_miss_iv", {31'd0, bus.inst_valid}, 32'd0);
      mem_return(32'h5555_5555);
      chk("postrst_fill", bus.inst, 32'h5555_5555);
      tick();
`ifdef ICACHE_INVALIDATE_EN
      request(32'h0000_0100);
      mem_return(32'h00A0_0093);
      tick();
      invalidate = 1'b1;
      tick();
      invalidate = 1'b0;
      request(32'h0000_0100);
      chk("inv_miss_fe", {31'd0, bus.fetch_enable}, 32'd1);
      chk("inv_miss_iv", {31'd0, bus.inst_valid}, 32'd0);
      mem_return(32'h00A0_0093);
      tick();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
